// File: rtl/ita_step_sequencer.sv
// ITA step sequencer: latches a layer configuration on start and issues (step, head, tile)
// commands to the attention engine one at a time, in the order Q, K, V, QK, AV, OW per head.
// Only one command is ever outstanding; the next is issued after the engine's tile_done_i.
module ita_step_sequencer #(
  parameter int unsigned H            = 1,
  parameter int unsigned TileCntWidth = 32,
  localparam int unsigned HeadW       = (H + 1 > 1) ? $clog2(H + 1) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [HeadW-1:0]        n_heads_i,
  input  logic [TileCntWidth-1:0] lin_tiles_i,
  input  logic [TileCntWidth-1:0] attn_tiles_i,
  output logic [2:0]              step_o,
  output logic [HeadW-1:0]        head_idx_o,
  output logic [TileCntWidth-1:0] tile_idx_o,
  output logic                    cmd_valid_o,
  input  logic                    cmd_ready_i,
  input  logic                    tile_done_i,
  output logic                    busy_o,
  output logic                    done_o
);

  typedef enum logic [2:0] {
    StepQ    = 3'd0,
    StepK    = 3'd1,
    StepV    = 3'd2,
    StepQk   = 3'd3,
    StepAv   = 3'd4,
    StepOw   = 3'd5,
    StepIdle = 3'd6
  } step_e;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StFinish
  } state_e;

  // QK and AV run over attention tiles, every other step over linear tiles.
  function automatic logic step_nonempty(step_e s, logic lin_nz, logic attn_nz);
    if (s == StepQk || s == StepAv) begin
      return attn_nz;
    end
    return (s != StepIdle) && lin_nz;
  endfunction

  // First non-empty step strictly after s, or StepIdle when the head is exhausted.
  function automatic step_e step_after(step_e s, logic lin_nz, logic attn_nz);
    step_e res;
    res = StepIdle;
    for (int i = 5; i >= 0; i--) begin
      if (i > int'(s) && step_nonempty(step_e'(3'(i)), lin_nz, attn_nz)) begin
        res = step_e'(3'(i));
      end
    end
    return res;
  endfunction

  state_e                  state_q;
  step_e                   step_q;
  logic [HeadW-1:0]        head_q;
  logic [TileCntWidth-1:0] tile_q;
  logic [HeadW-1:0]        n_heads_q;
  logic [TileCntWidth-1:0] lin_q;
  logic [TileCntWidth-1:0] attn_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    done_q;

  // Start-time decode, taken straight from the inputs since they are latched on the same edge.
  logic [HeadW-1:0] n_heads_clamped;
  logic             lin_nz_in;
  logic             attn_nz_in;
  logic             empty_layer_in;
  step_e            first_step_in;

  // Advance decode for the latched configuration.
  logic                    lin_nz_q;
  logic                    attn_nz_q;
  step_e                   first_step_q;
  logic [TileCntWidth-1:0] cur_cnt;
  logic                    last_tile;
  logic                    last_head;
  step_e                   next_step;

  // Derive start decisions and the tile/step/head advance conditions.
  always_comb begin
    n_heads_clamped = (n_heads_i > HeadW'(H)) ? HeadW'(H) : n_heads_i;
    lin_nz_in       = (lin_tiles_i != '0);
    attn_nz_in      = (attn_tiles_i != '0);
    empty_layer_in  = (n_heads_clamped == '0) || (!lin_nz_in && !attn_nz_in);
    first_step_in   = lin_nz_in ? StepQ : StepQk;

    lin_nz_q     = (lin_q != '0);
    attn_nz_q    = (attn_q != '0);
    first_step_q = lin_nz_q ? StepQ : StepQk;
    cur_cnt      = (step_q == StepQk || step_q == StepAv) ? attn_q : lin_q;
    // Only reached for non-empty steps, so cur_cnt - 1 never wraps.
    last_tile    = (tile_q == cur_cnt - TileCntWidth'(1));
    last_head    = (head_q == n_heads_q - HeadW'(1));
    next_step    = step_after(step_q, lin_nz_q, attn_nz_q);
  end

  // Sequencer FSM with registered command and status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      step_q    <= StepIdle;
      head_q    <= '0;
      tile_q    <= '0;
      n_heads_q <= '0;
      lin_q     <= '0;
      attn_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            n_heads_q <= n_heads_clamped;
            lin_q     <= lin_tiles_i;
            attn_q    <= attn_tiles_i;
            head_q    <= '0;
            tile_q    <= '0;
            if (empty_layer_in) begin
              state_q <= StFinish;
              done_q  <= 1'b1;
            end else begin
              state_q <= StIssue;
              step_q  <= first_step_in;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (cmd_ready_i) begin
            state_q <= StWait;
            valid_q <= 1'b0;
          end
        end
        StWait: begin
          if (tile_done_i) begin
            if (!last_tile) begin
              tile_q  <= tile_q + TileCntWidth'(1);
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else if (next_step != StepIdle) begin
              step_q  <= next_step;
              tile_q  <= '0;
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else if (!last_head) begin
              head_q  <= head_q + HeadW'(1);
              step_q  <= first_step_q;
              tile_q  <= '0;
              state_q <= StIssue;
              valid_q <= 1'b1;
            end else begin
              step_q  <= StepIdle;
              head_q  <= '0;
              tile_q  <= '0;
              state_q <= StFinish;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        StFinish: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign step_o      = step_q;
  assign head_idx_o  = head_q;
  assign tile_idx_o  = tile_q;
  assign cmd_valid_o = valid_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_ita_step_sequencer.sv
// Directed bench for ita_step_sequencer: a scoreboard of expected commands is filled when a
// layer is started and drained as the DUT fires commands at a bench-modelled engine.
module tb_ita_step_sequencer;

  localparam int unsigned H     = 2;
  localparam int unsigned TW    = 32;
  localparam int unsigned HeadW = $clog2(H + 1);

  logic            clk;
  logic            rst_i;
  logic            start_i;
  logic [HeadW-1:0] n_heads_i;
  logic [TW-1:0]   lin_tiles_i;
  logic [TW-1:0]   attn_tiles_i;
  logic [2:0]      step_o;
  logic [HeadW-1:0] head_idx_o;
  logic [TW-1:0]   tile_idx_o;
  logic            cmd_valid_o;
  logic            cmd_ready_i;
  logic            tile_done_i;
  logic            busy_o;
  logic            done_o;

  ita_step_sequencer #(
    .H           (H),
    .TileCntWidth(TW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .n_heads_i   (n_heads_i),
    .lin_tiles_i (lin_tiles_i),
    .attn_tiles_i(attn_tiles_i),
    .step_o      (step_o),
    .head_idx_o  (head_idx_o),
    .tile_idx_o  (tile_idx_o),
    .cmd_valid_o (cmd_valid_o),
    .cmd_ready_i (cmd_ready_i),
    .tile_done_i (tile_done_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int step;
    int head;
    int tile;
  } cmd_t;

  cmd_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   since_ev = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference order: per head, steps Q,K,V,QK,AV,OW, each over its own tile count.
  task automatic push_expected(input int n, input int lin, input int attn);
    int nc;
    int cnt;
    nc = (n > int'(H)) ? int'(H) : n;
    for (int h = 0; h < nc; h++) begin
      for (int s = 0; s < 6; s++) begin
        cnt = (s == 3 || s == 4) ? attn : lin;
        for (int t = 0; t < cnt; t++) begin
          exp_q.push_back('{step: s, head: h, tile: t});
        end
      end
    end
  endtask

  // Called on a falling edge; returns on the falling edge after start was sampled.
  task automatic start_layer(input int n, input int lin, input int attn);
    logic nonempty;
    nonempty = (n != 0) && (lin != 0 || attn != 0);
    push_expected(n, lin, attn);
    start_i      = 1'b1;
    n_heads_i    = HeadW'(n);
    lin_tiles_i  = TW'(lin);
    attn_tiles_i = TW'(attn);
    @(negedge clk);
    start_i  = 1'b0;
    since_ev = 1;
    check("start_valid_latency", cmd_valid_o, nonempty);
    check("start_busy", busy_o, nonempty);
  endtask

  // Engine model: fires every valid command, returns tile_done 2 cycles after each fire.
  task automatic run_engine(input int abort_at, input int inject_at, input bit slack);
    int   cd = -1;
    int   fired = 0;
    bit   finished = 0;
    bit   abort_pending = 0;
    cmd_t e;
    for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
      start_i     = 1'b0;
      tile_done_i = 1'b0;
      if (done_o) begin
        check("done_queue_drained", exp_q.size(), 0);
        check("done_busy_low", busy_o, 0);
        check("done_step_idle", step_o, 6);
        check("done_valid_low", cmd_valid_o, 0);
        check("done_latency", (since_ev == 1) || (slack && since_ev == 2), 1);
        @(negedge clk);
        check("done_one_cycle", done_o, 0);
        finished = 1;
      end else if (abort_pending) begin
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("rst_step", step_o, 6);
        check("rst_head", head_idx_o, 0);
        check("rst_tile", tile_idx_o, 0);
        check("rst_valid", cmd_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("rst_no_done", done_o, 0);
          check("rst_no_cmd", cmd_valid_o, 0);
        end
        exp_q.delete();
        finished = 1;
      end else begin
        if (cd > 0) begin
          check("valid_low_in_wait", cmd_valid_o, 0);
          cd--;
          if (cd == 0) begin
            tile_done_i = 1'b1;
            since_ev    = 0;
            cd          = -1;
          end
        end else if (cmd_valid_o) begin
          check("busy_while_cmd", busy_o, 1);
          check("cmd_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("cmd_step", step_o, e.step);
            check("cmd_head", head_idx_o, e.head);
            check("cmd_tile", tile_idx_o, e.tile);
          end
          fired++;
          cd = 2;
          if (fired == inject_at) begin
            start_i      = 1'b1;
            n_heads_i    = 2'd2;
            lin_tiles_i  = 7;
            attn_tiles_i = 0;
          end
          if (fired == abort_at) abort_pending = 1;
        end
        @(negedge clk);
        since_ev++;
      end
    end
    check("layer_completed_in_budget", finished, 1);
    start_i     = 1'b0;
    tile_done_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    n_heads_i    = '0;
    lin_tiles_i  = '0;
    attn_tiles_i = '0;
    cmd_ready_i  = 1'b1;
    tile_done_i  = 1'b0;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    check("reset_step", step_o, 6);
    check("reset_head", head_idx_o, 0);
    check("reset_tile", tile_idx_o, 0);
    check("reset_valid", cmd_valid_o, 0);
    check("reset_busy", busy_o, 0);
    check("reset_done", done_o, 0);
    @(negedge clk);

    // Single head, 10 commands.
    start_layer(1, 2, 1);
    run_engine(0, 0, 0);

    // Two heads, attention tiles 0..2.
    start_layer(2, 1, 3);
    run_engine(0, 0, 0);

    // Stall with ready low; a spurious tile_done in ISSUE must not advance.
    start_layer(1, 1, 1);
    cmd_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", cmd_valid_o, 1);
      check("stall_step", step_o, 0);
      check("stall_head", head_idx_o, 0);
      check("stall_tile", tile_idx_o, 0);
      tile_done_i = (i == 2);
      @(negedge clk);
    end
    tile_done_i = 1'b0;
    cmd_ready_i = 1'b1;
    run_engine(0, 0, 0);

    // Empty layers.
    start_layer(0, 3, 3);
    run_engine(0, 0, 1);
    start_layer(2, 0, 0);
    run_engine(0, 0, 1);

    // No attention tiles: only Q, K, V, OW.
    start_layer(1, 1, 0);
    run_engine(0, 0, 0);

    // Start with a different config mid-layer is ignored.
    start_layer(1, 2, 1);
    run_engine(0, 3, 0);

    // Head count above H is clamped.
    start_layer(3, 1, 0);
    run_engine(0, 0, 0);

    // Reset while waiting on (K,1), then a fresh full run.
    start_layer(1, 2, 1);
    run_engine(4, 0, 0);
    start_layer(1, 2, 1);
    run_engine(0, 0, 0);

    // Reset wins over a simultaneous start.
    rst_i        = 1'b1;
    start_i      = 1'b1;
    n_heads_i    = 2'd1;
    lin_tiles_i  = 1;
    attn_tiles_i = 1;
    @(negedge clk);
    rst_i   = 1'b0;
    start_i = 1'b0;
    check("rst_start_busy", busy_o, 0);
    check("rst_start_valid", cmd_valid_o, 0);
    @(negedge clk);
    check("rst_start_still_idle", busy_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
